valid_stream_deserializer: RTL

VALID_STREAM_DESERIALIZER -- requirements
Module: valid_stream_deserializer

---
 rtl/valid_stream_deserializer.sv | 73 +++++++
 1 files changed

// File: rtl/valid_stream_deserializer.sv
// Valid-gated beat-to-word deserializer: packs up to `depth` beats of `width` bits
// LSB-first into one word, completing early on in_last, with a one-cycle output pulse.
module valid_stream_deserializer #(
  parameter int width = 8,
  parameter int depth = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_vld,
  input  logic [width-1:0]             in_data,
  input  logic                         in_last,
  output logic                         out_vld,
  output logic [width*depth-1:0]       out_data,
  output logic [$clog2(depth+1)-1:0]   out_count
);

  localparam int CNT_W = $clog2(depth);
  localparam int OC_W  = $clog2(depth+1);

  typedef enum logic {IDLE, COLLECT} state_e;

  state_e                        state_q;
  logic [CNT_W-1:0]              cnt_q;
  logic [depth-1:0][width-1:0]   buf_q;
  logic [depth-1:0][width-1:0]   word_d;
  logic [depth-1:0][width-1:0]   out_data_q;
  logic [OC_W-1:0]               out_count_q;
  logic                          out_vld_q;
  logic [CNT_W-1:0]              slot;
  logic                          done;

  assign slot = (state_q == IDLE) ? '0 : cnt_q;
  assign done = in_vld && (in_last || slot == CNT_W'(depth-1));

  // Completing beat merges into the buffer snapshot; slots above it are still
  // zero because the buffer is cleared at every completion.
  always_comb begin
    word_d       = buf_q;
    word_d[slot] = in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      buf_q       <= '0;
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      out_vld_q <= 1'b0;
      if (in_vld) begin
        if (done) begin
          out_vld_q   <= 1'b1;
          out_data_q  <= word_d;
          out_count_q <= OC_W'(slot) + OC_W'(1);
          buf_q       <= '0;
          cnt_q       <= '0;
          state_q     <= IDLE;
        end else begin
          buf_q[slot] <= in_data;
          cnt_q       <= slot + CNT_W'(1);
          state_q     <= COLLECT;
        end
      end
    end
  end

  assign out_vld   = out_vld_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;

endmodule
